// File: rtl/dct_arbiter.sv
// dct_arbiter -- shares one in-order blockDCT core between N_REQ requesters.
//
// A round-robin arbiter forwards one requester packet per cycle to the core
// and records the winner's index in a source-tag FIFO. Results coming back
// from the core are routed to the requester whose tag sits at the FIFO head.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   req_data/valid   requester packets in (requester k at [k*total_width +: total_width])
//   req_ready        per-requester accept (only the winner, only on accept)
//   dct_i_*          packet channel towards the core
//   dct_o_*          result channel from the core
//   rsp_data/valid   result broadcast / one-hot owner valid
//   rsp_ready        per-requester result ready
//   outstanding      packets in flight (0..TAG_DEPTH)
//   err              sticky: core produced a result with no outstanding tag
//
// Optional feature: define DCT_ARB_STATS_EN to add output grant_cnt with a
// saturating 16-bit accept counter per requester.

module dct_arbiter #(
   parameter int N_REQ       = 4,
   parameter int total_width = 274,
   parameter int TAG_DEPTH   = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [N_REQ*total_width-1:0] req_data,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   output logic [total_width-1:0]       dct_i_data,
   output logic                         dct_i_valid,
   input  logic                         dct_o_ready,
   input  logic [total_width-1:0]       dct_o_data,
   input  logic                         dct_o_valid,
   output logic                         dct_i_ready,
   output logic [total_width-1:0]       rsp_data,
   output logic [N_REQ-1:0]             rsp_valid,
   input  logic [N_REQ-1:0]             rsp_ready,
   output logic [$clog2(TAG_DEPTH):0]   outstanding,
   output logic                         err
`ifdef DCT_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]          grant_cnt
`endif
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q;
   logic [IDX_W-1:0] tag_mem [TAG_DEPTH];

   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] head;
   logic             any_valid, full, empty, push, pop;

   assign full  = (count_q == CNT_W'(TAG_DEPTH));
   assign empty = (count_q == '0);
   assign head  = tag_mem[rd_ptr_q];

   // Round-robin search: the first valid requester at or after ptr_q wins.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path can infer a latch.
      any_valid = 1'b0;
      winner    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!any_valid && req_valid[(int'(ptr_q) + i) % N_REQ]) begin
            any_valid = 1'b1;
            winner    = IDX_W'((int'(ptr_q) + i) % N_REQ);
         end
      end
   end

   // All handshake outputs are forced low while rstn is held, independent of clk.
   always_comb begin
      dct_i_valid = rstn && any_valid && !full;
      dct_i_data  = rstn ? req_data[int'(winner)*total_width +: total_width] : '0;
      req_ready   = '0;
      if (dct_i_valid && dct_o_ready) begin
         req_ready[winner] = 1'b1;
      end
      rsp_data    = rstn ? dct_o_data : '0;
      rsp_valid   = '0;
      dct_i_ready = 1'b0;
      if (rstn) begin
         if (empty) begin
            // Orphan results are drained so the core never stalls on them.
            dct_i_ready = 1'b1;
         end else begin
            rsp_valid[head] = dct_o_valid;
            dct_i_ready     = rsp_ready[head];
         end
      end
   end

   assign push = dct_i_valid & dct_o_ready;
   assign pop  = dct_o_valid & dct_i_ready & ~empty;

   always_comb begin
      ptr_d = ptr_q;
      if (push) begin
         ptr_d = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         ptr_q   <= ptr_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (dct_o_valid && empty) err_q <= 1'b1;
      end
   end

   // NOTE: tag storage has no reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr_q] <= winner;
   end

   assign outstanding = count_q;
   assign err         = err_q;

`ifdef DCT_ARB_STATS_EN
   logic [15:0] grant_cnt_q [N_REQ];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < N_REQ; k++) grant_cnt_q[k] <= '0;
      end else if (push && grant_cnt_q[winner] != 16'hFFFF) begin
         grant_cnt_q[winner] <= grant_cnt_q[winner] + 16'd1;
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int k = 0; k < N_REQ; k++) grant_cnt[k*16 +: 16] = grant_cnt_q[k];
   end
`endif

endmodule

// File: tb/tb_dct_arbiter.sv
// tb_dct_arbiter -- self-checking bench for dct_arbiter (N_REQ=4, TAG_DEPTH=16).
// Directed scenarios plus a randomized run compared against a queue-based
// reference model. Build with DCT_ARB_STATS_EN defined to also check grant_cnt.

module tb_dct_arbiter;
   localparam int N = 4;
   localparam int W = 274;
   localparam int D = 16;

   logic           clk = 1'b0;
   logic           rstn;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [W-1:0]   dct_i_data, dct_o_data, rsp_data;
   logic           dct_i_valid, dct_o_ready, dct_o_valid, dct_i_ready, err;
   logic [4:0]     outstanding;
`ifdef DCT_ARB_STATS_EN
   logic [N*16-1:0] grant_cnt;
`endif

   dct_arbiter #(.N_REQ(N), .total_width(W), .TAG_DEPTH(D)) dut (
      .clk(clk), .rstn(rstn),
      .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
      .dct_i_data(dct_i_data), .dct_i_valid(dct_i_valid), .dct_o_ready(dct_o_ready),
      .dct_o_data(dct_o_data), .dct_o_valid(dct_o_valid), .dct_i_ready(dct_i_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .outstanding(outstanding), .err(err)
`ifdef DCT_ARB_STATS_EN
      , .grant_cnt(grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of owner indices in flight, next-search pointer, sticky error.
   int  q[$];
   int  m_ptr;
   bit  m_err;
   int  m_cnt[N];

   int           e_win;
   bit           e_any, e_empty, e_ivalid, e_push, e_pop, e_iready;
   logic [N-1:0] e_req_ready, e_rsp_valid;

   task automatic model_reset();
      q.delete();
      m_ptr = 0;
      m_err = 1'b0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
   endtask

   task automatic model_eval();
      e_any = 1'b0;
      e_win = 0;
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_ptr + i) % N;
         if (!e_any && req_valid[k]) begin
            e_any = 1'b1;
            e_win = k;
         end
      end
      e_ivalid    = e_any && (q.size() < D);
      e_push      = e_ivalid && dct_o_ready;
      e_req_ready = '0;
      if (e_push) e_req_ready[e_win] = 1'b1;
      e_empty     = (q.size() == 0);
      e_rsp_valid = '0;
      e_iready    = 1'b1;
      if (!e_empty) begin
         e_rsp_valid[q[0]] = dct_o_valid;
         e_iready          = rsp_ready[q[0]];
      end
      e_pop = !e_empty && dct_o_valid && e_iready;
   endtask

   task automatic model_commit();
      if (dct_o_valid && e_empty) m_err = 1'b1;
      if (e_pop) void'(q.pop_front());
      if (e_push) begin
         q.push_back(e_win);
         m_ptr = (e_win + 1) % N;
         if (m_cnt[e_win] < 65535) m_cnt[e_win]++;
      end
   endtask

   task automatic settle();
      model_eval();
      #1;
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      req_valid   = '0;
      dct_o_valid = 1'b0;
      settle();
      advance();
   endtask

   task automatic rand_data();
      for (int b = 0; b < N*W; b++) req_data[b] = 1'($urandom);
      for (int b = 0; b < W; b++) dct_o_data[b] = 1'($urandom);
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      req_valid = '1; dct_o_ready = 1'b1; dct_o_valid = 1'b1; rsp_ready = '1;
      rand_data();
      #1 rstn = 1'b0;
      #2;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      checks++; if (dct_i_valid !== 1'b0) begin errors++; $display("FAIL reset_dct_i_valid got %b exp 0", dct_i_valid); end
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
      checks++; if (dct_i_ready !== 1'b0) begin errors++; $display("FAIL reset_dct_i_ready got %b exp 0", dct_i_ready); end
      checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      @(negedge clk);
      req_valid = '0; dct_o_valid = 1'b0;
      rstn = 1'b1;
      model_reset();
   endtask

   task automatic test_round_robin();
      int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      logic [N-1:0] exp_oh;
      req_valid = '1; dct_o_ready = 1'b1; dct_o_valid = 1'b0; rsp_ready = '1;
      for (int i = 0; i < 8; i++) begin
         rand_data();
         settle();
         exp_oh = '0; exp_oh[exp_seq[i]] = 1'b1;
         checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, req_ready, exp_oh); end
         checks++; if (dct_i_data !== req_data[exp_seq[i]*W +: W]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, dct_i_data, req_data[exp_seq[i]*W +: W]); end
         advance();
      end
      req_valid = '0;
      settle();
      checks++; if (outstanding !== 5'd8) begin errors++; $display("FAIL rr_outstanding got %0d exp 8", outstanding); end
      dct_o_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_data();
         settle();
         exp_oh = '0; exp_oh[exp_seq[i]] = 1'b1;
         checks++; if (rsp_valid !== exp_oh) begin errors++; $display("FAIL rr_rsp_valid[%0d] got %b exp %b", i, rsp_valid, exp_oh); end
         checks++; if (rsp_data !== dct_o_data) begin errors++; $display("FAIL rr_rsp_data[%0d] got %h exp %h", i, rsp_data, dct_o_data); end
         advance();
      end
      dct_o_valid = 1'b0;
      settle();
      checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL rr_drained got %0d exp 0", outstanding); end
      idle_cycle();
   endtask

   task automatic test_single_requester();
      req_valid = 4'b0100; dct_o_ready = 1'b1; dct_o_valid = 1'b0; rsp_ready = '1;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         settle();
         checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant[%0d] got %b exp 0100", i, req_ready); end
         advance();
      end
      // Pointer now sits at 3: with everyone requesting, requester 3 is selected.
      req_valid = '1; dct_o_ready = 1'b0;
      rand_data();
      settle();
      checks++; if (dct_i_data !== req_data[3*W +: W]) begin errors++; $display("FAIL single_ptr got %h exp %h", dct_i_data, req_data[3*W +: W]); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_not_ready got %b exp 0000", req_ready); end
      advance();
      req_valid = '0; dct_o_ready = 1'b1; dct_o_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         settle();
         checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp[%0d] got %b exp 0100", i, rsp_valid); end
         advance();
      end
      idle_cycle();
   endtask

   task automatic test_fifo_full();
      req_valid = '1; dct_o_ready = 1'b1; dct_o_valid = 1'b0; rsp_ready = '1;
      for (int i = 0; i < D; i++) begin
         settle();
         checks++; if (dct_i_valid !== 1'b1) begin errors++; $display("FAIL full_fill[%0d] got %b exp 1", i, dct_i_valid); end
         advance();
      end
      settle();
      checks++; if (dct_i_valid !== 1'b0) begin errors++; $display("FAIL full_valid got %b exp 0", dct_i_valid); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_req_ready got %b exp 0000", req_ready); end
      checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL full_outstanding got %0d exp 16", outstanding); end
      advance();
      dct_o_valid = 1'b1;
      settle();
      checks++; if (dct_i_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b exp 1", dct_i_ready); end
      checks++; if (dct_i_valid !== 1'b0) begin errors++; $display("FAIL full_pop_nopush got %b exp 0", dct_i_valid); end
      advance();
      dct_o_valid = 1'b0;
      settle();
      checks++; if (outstanding !== 5'd15) begin errors++; $display("FAIL full_after_pop got %0d exp 15", outstanding); end
      checks++; if (dct_i_valid !== 1'b1) begin errors++; $display("FAIL full_repush got %b exp 1", dct_i_valid); end
      advance();
      settle();
      checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL full_refilled got %0d exp 16", outstanding); end
      req_valid = '0; dct_o_valid = 1'b1;
      for (int i = 0; i < D; i++) begin
         settle();
         checks++; if (rsp_valid !== e_rsp_valid) begin errors++; $display("FAIL full_drain[%0d] got %b exp %b", i, rsp_valid, e_rsp_valid); end
         advance();
      end
      dct_o_valid = 1'b0;
      settle();
      checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", outstanding); end
      idle_cycle();
   endtask

   task automatic test_backpressure();
      req_valid = 4'b0010; dct_o_ready = 1'b1; dct_o_valid = 1'b0;
      settle();
      advance();
      req_valid = '0; dct_o_valid = 1'b1; rsp_ready = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++; if (dct_i_ready !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d] got %b exp 0", i, dct_i_ready); end
         checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_rsp[%0d] got %b exp 0010", i, rsp_valid); end
         advance();
      end
      settle();
      checks++; if (outstanding !== 5'd1) begin errors++; $display("FAIL bp_held got %0d exp 1", outstanding); end
      rsp_ready = '1;
      settle();
      checks++; if (dct_i_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", dct_i_ready); end
      advance();
      dct_o_valid = 1'b0;
      settle();
      checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL bp_single_pop got %0d exp 0", outstanding); end
      idle_cycle();
   endtask

   task automatic test_err();
      settle();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_initial got %b exp 0", err); end
      dct_o_valid = 1'b1; rsp_ready = '0;
      settle();
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL err_rsp_valid got %b exp 0000", rsp_valid); end
      checks++; if (dct_i_ready !== 1'b1) begin errors++; $display("FAIL err_drain got %b exp 1", dct_i_ready); end
      advance();
      dct_o_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d] got %b exp 1", i, err); end
         advance();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         req_valid   = N'($urandom);
         dct_o_ready = ($urandom_range(0, 3) != 0);
         dct_o_valid = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         rsp_ready   = N'($urandom);
         rand_data();
         settle();
         checks++; if (req_ready !== e_req_ready) begin errors++; $display("FAIL rnd_req_ready[%0d] got %b exp %b", i, req_ready, e_req_ready); end
         checks++; if (dct_i_valid !== e_ivalid) begin errors++; $display("FAIL rnd_i_valid[%0d] got %b exp %b", i, dct_i_valid, e_ivalid); end
         if (e_any) begin
            checks++; if (dct_i_data !== req_data[e_win*W +: W]) begin errors++; $display("FAIL rnd_i_data[%0d] got %h exp %h", i, dct_i_data, req_data[e_win*W +: W]); end
         end
         checks++; if (rsp_valid !== e_rsp_valid) begin errors++; $display("FAIL rnd_rsp_valid[%0d] got %b exp %b", i, rsp_valid, e_rsp_valid); end
         if (!e_empty || dct_o_valid) begin
            checks++; if (dct_i_ready !== e_iready) begin errors++; $display("FAIL rnd_i_ready[%0d] got %b exp %b", i, dct_i_ready, e_iready); end
         end
         checks++; if (outstanding !== 5'(q.size())) begin errors++; $display("FAIL rnd_outstanding[%0d] got %0d exp %0d", i, outstanding, q.size()); end
         checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", i, err, m_err); end
         advance();
      end
`ifdef DCT_ARB_STATS_EN
      for (int k = 0; k < N; k++) begin
         checks++; if (grant_cnt[k*16 +: 16] !== 16'(m_cnt[k])) begin errors++; $display("FAIL rnd_grant_cnt[%0d] got %0d exp %0d", k, grant_cnt[k*16 +: 16], m_cnt[k]); end
      end
`endif
      idle_cycle();
   endtask

   task automatic test_reset_mid_operation();
      #2 rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      req_valid = '1; dct_o_ready = 1'b1; dct_o_valid = 1'b0; rsp_ready = '1;
      for (int i = 0; i < 5; i++) begin
         settle();
         advance();
      end
      req_valid = '0;
      settle();
      checks++; if (outstanding !== 5'd5) begin errors++; $display("FAIL rstmid_before got %0d exp 5", outstanding); end
      req_valid = '1; dct_o_valid = 1'b1;
      rand_data();
      #2 rstn = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_req_ready got %b exp 0000", req_ready); end
      checks++; if (dct_i_valid !== 1'b0) begin errors++; $display("FAIL rstmid_i_valid got %b exp 0", dct_i_valid); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_rsp_valid got %b exp 0000", rsp_valid); end
      checks++; if (dct_i_ready !== 1'b0) begin errors++; $display("FAIL rstmid_i_ready got %b exp 0", dct_i_ready); end
      checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL rstmid_outstanding got %0d exp 0", outstanding); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", err); end
      checks++; if (dct_i_data !== '0) begin errors++; $display("FAIL rstmid_i_data got %h exp 0", dct_i_data); end
`ifdef DCT_ARB_STATS_EN
      checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL rstmid_grant_cnt got %h exp 0", grant_cnt); end
`endif
      @(negedge clk);
      req_valid = '0; dct_o_valid = 1'b0;
      rstn = 1'b1;
      model_reset();
      req_valid = '1;
      settle();
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got %b exp 0001", req_ready); end
      advance();
      idle_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single_requester();
      test_fifo_full();
      test_backpressure();
      test_err();
      test_random();
      test_reset_mid_operation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dct_arbiter.md
DCT_ARBITER -- requirements
Module: dct_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one blockDCT core (2..8).
REQ-002 SHALL have parameter total_width, default 274, packet width: x(2)+y(2)+pck_num(14)+data(256).
REQ-003 SHALL have parameter TAG_DEPTH, default 16, source-tag FIFO depth, power of two.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_data  input  N_REQ*total_width  requester packets; requester k at bits [k*total_width +: total_width].
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester packet valid.
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester accept.
REQ-009 SHALL have port dct_i_data  output  total_width  packet to core.
REQ-010 SHALL have port dct_i_valid  output  1  valid to core.
REQ-011 SHALL have port dct_o_ready  input  1  core ready to accept.
REQ-012 SHALL have port dct_o_data  input  total_width  result from core.
REQ-013 SHALL have port dct_o_valid  input  1  core result valid.
REQ-014 SHALL have port dct_i_ready  output  1  arbiter ready to take core result.
REQ-015 SHALL have port rsp_data  output  total_width  result, broadcast to all requesters.
REQ-016 SHALL have port rsp_valid  output  N_REQ  one-hot result valid to owner.
REQ-017 SHALL have port rsp_ready  input  N_REQ  per-requester result ready.
REQ-018 SHALL have port outstanding  output  $clog2(TAG_DEPTH)+1  packets in flight.
REQ-019 SHALL have port err  output  1  sticky: core result with no outstanding tag.

Function
REQ-020 SHALL arbitrate round-robin; search starts at pointer ptr, wraps N_REQ-1 -> 0.
REQ-021 SHALL drive dct_i_valid = any req_valid AND tag FIFO not full; dct_i_data = winner's req_data, combinational, zero latency.
REQ-022 SHALL assert req_ready only to the winner, only when dct_o_ready=1 and tag FIFO not full; all others 0.
REQ-023 SHALL, on accept (dct_i_valid & dct_o_ready), push winner index into tag FIFO and set ptr = winner+1 (mod N_REQ); ptr otherwise unchanged.
REQ-024 SHALL hold grant decision stable while dct_o_ready=0 is not required; arbitration is re-evaluated every cycle.
REQ-025 SHALL, with tag FIFO non-empty, drive rsp_valid[head]=dct_o_valid, other bits 0, rsp_data=dct_o_data, dct_i_ready=rsp_ready[head].
REQ-026 SHALL pop tag FIFO on dct_o_valid & dct_i_ready with FIFO non-empty.
REQ-027 SHALL, when full, block push even if a pop occurs the same cycle; push and pop in one cycle when not full keeps outstanding unchanged.
REQ-028 SHALL, with FIFO empty and dct_o_valid=1, drive dct_i_ready=1 (drain), rsp_valid=0, and set err.
REQ-029 SHALL keep outstanding = push count minus pop count, range 0..TAG_DEPTH.
REQ-030 SHALL preserve in-order result routing; core is in-order.

Reset
REQ-031 SHALL on rstn=0 immediately clear ptr=0, FIFO pointers, outstanding=0, err=0.
REQ-032 SHALL, during reset, drive req_ready=0, dct_i_valid=0, rsp_valid=0, dct_i_ready=0.
REQ-033 SHALL discard in-flight tags on reset mid-operation; core is reset by the same rstn.

Configuration
REQ-034 SHALL, with macro DCT_ARB_STATS_EN defined, add output grant_cnt (N_REQ*16 bits), per-requester saturating 16-bit accept counters, cleared by reset.
REQ-035 SHALL, without DCT_ARB_STATS_EN, have no grant_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-036 SHALL verify: all 4 req_valid=1, dct_o_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; outstanding=8.
REQ-037 SHALL verify: only req 2 valid, 3 packets -> all granted to 2, ptr=3; results return with rsp_valid=4'b0100 three times.
REQ-038 SHALL verify: TAG_DEPTH=16, core never returns -> 16 accepts then req_ready=0, dct_i_valid=0, outstanding=16; one pop with same-cycle request -> no push that cycle, push next cycle.
REQ-039 SHALL verify: head tag=1, rsp_ready[1]=0, dct_o_valid=1 -> dct_i_ready=0 until rsp_ready[1]=1, then single pop.
REQ-040 SHALL verify: dct_o_valid=1 with outstanding=0 -> err=1 sticky, rsp_valid=0, dct_i_ready=1.
REQ-041 SHALL verify: rstn=0 with outstanding=5 -> all outputs 0 asynchronously, outstanding=0, err=0; with DCT_ARB_STATS_EN, grant_cnt=0.
